fp_addsub_issue: RTL
====================

FP_ADDSUB_ISSUE -- requirements
Module: fp_addsub_issue

Interface
REQ-001 Parameter: DEPTH, default 4, maximum number of operations outstanding in the add/sub core.
REQ-002 Parameter: TAG_W, default 4, width of the command tag.
REQ-003 Port: clock  in  1  single clock; all logic on its rising edge.
REQ-004 Port: rstn  in  1  reset, asynchronous, active-low.
REQ-005 Ports: cmd_valid in 1, cmd_ready out 1, cmd_a in 32, cmd_b in 32, cmd_op in 1 (0 add, 1 sub), cmd_tag in TAG_W; upstream command channel.
REQ-006 Ports: s_axis_a_tvalid out 1, s_axis_a_tready in 1, s_axis_a_tdata out 32; operand A to the add/sub core.
REQ-007 Ports: s_axis_b_tvalid out 1, s_axis_b_tready in 1, s_axis_b_tdata out 32; operand B to the core.
REQ-008 Ports: s_axis_operation_tvalid out 1, s_axis_operation_tready in 1, s_axis_operation_tdata out 8; operation to the core.
REQ-009 Ports: m_axis_result_tvalid in 1, m_axis_result_tready out 1, m_axis_result_tdata in 32; result from the core.
REQ-010 Ports: rsp_valid out 1, rsp_ready in 1, rsp_data out 32, rsp_tag out TAG_W; downstream response channel.
REQ-011 Port: err_orphan  out  1  sticky flag: a result arrived with no tag outstanding.

Function
REQ-012 The command handshake occurs when cmd_valid and cmd_ready are both high at a rising edge.
REQ-013 The issue FSM has two states: IDLE and SEND.
REQ-014 cmd_ready is high only when the FSM is in IDLE and the registered outstanding count is below DEPTH.
REQ-015 On the command handshake, the block latches A, B, op and tag, pushes the tag into the tag FIFO, moves to SEND, and raises all three core tvalids on the next cycle.
REQ-016 s_axis_operation_tdata is {7'b0, op}.
REQ-017 In SEND, each channel keeps its tvalid and data stable until its own tready handshake, then drops its tvalid; channels complete independently and in any order.
REQ-018 The FSM returns to IDLE in the cycle in which the last pending channel handshakes; cmd_ready may rise in the following cycle.
REQ-019 The outstanding count increments on the command handshake and decrements on the result handshake; simultaneous push and pop leave it unchanged; the count never exceeds DEPTH.
REQ-020 m_axis_result_tready = !rsp_valid || rsp_ready.
REQ-021 On the result handshake, the block loads rsp_data with the result, loads rsp_tag with the tag FIFO head, pops the FIFO, and asserts rsp_valid on the next cycle (1-cycle latency).
REQ-022 rsp_valid, rsp_data and rsp_tag stay stable until rsp_ready; back-to-back results at full throughput are supported.
REQ-023 Tags are returned in issue order, because the core is in-order.
REQ-024 A result handshake with the tag FIFO empty is consumed without a response, sets err_orphan, and leaves the count at 0.

Reset
REQ-025 rstn low asynchronously forces FSM=IDLE, all tvalids=0, rsp_valid=0, rsp_data=0, rsp_tag=0, count=0, FIFO pointers=0 and err_orphan=0.
REQ-026 A reset asserted mid-SEND or with operations outstanding discards them; no response is produced for those operations after reset is released.
REQ-027 After reset release, cmd_ready is high in the first cycle.

Structure
REQ-028 Package fp_issue_pkg holds OP_ADD=8'h00, OP_SUB=8'h01, the DEPTH and TAG_W defaults, and the FSM state enum.
REQ-029 The tag FIFO is a sub-module, fp_tag_fifo (DEPTH x TAG_W, synchronous, same clock and reset), providing full, empty and count outputs.

Verification
REQ-030 Scenario: A=0x3F800000, B=0x40000000, op=0, tag=3, all readys high -> rsp_data=0x40400000, rsp_tag=3; tvalids high exactly 1 cycle.
REQ-031 Scenario: s_axis_b_tready held low for 5 cycles -> A and op complete at once; B tvalid and data stay stable for 5 cycles; cmd_ready stays low until B is accepted.
REQ-032 Scenario: issue 4 commands (tags 0-3) with m_axis_result_tready stalled by holding rsp_ready low -> cmd_ready low after the 4th command; after release, responses return in tag order 0,1,2,3.
REQ-033 Scenario: A=0x40A00000, B=0x3F800000, op=1 -> rsp_data=0x40800000; s_axis_operation_tdata=0x01.
REQ-034 Scenario: rstn pulsed low with 2 operations outstanding -> all outputs at reset values immediately; no rsp_valid after release; next command returns normally.
REQ-035 Scenario: inject m_axis_result_tvalid with count=0 -> err_orphan=1 and stays 1; rsp_valid stays 0.

Source files
------------

// File: rtl/fp_issue_pkg.sv
// Shared constants and types for the FP add/sub issue block.
package fp_issue_pkg;

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;

    localparam int DEPTH_DEFAULT = 4;
    localparam int TAG_W_DEFAULT = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } issue_state_t;

endpackage

// File: rtl/fp_tag_fifo.sv
// Tag FIFO: holds the tags of operations in flight in the in-order core.
// The occupancy count doubles as the outstanding-operation count.
module fp_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             push,
    input  logic [TAG_W-1:0] push_tag,
    input  logic             pop,
    output logic [TAG_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TAG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (do_pop && !do_push)
                count <= count - CNT_W'(1);
        end
    end

    // Tag storage needs no reset: entries are only read between a push and its pop.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_tag;
    end

endmodule

// File: rtl/fp_addsub_issue.sv
// Issue/return wrapper around an AXI-stream floating-point add/sub core.
// Commands are split onto three independent operand channels; results are
// paired with their tags from an in-order tag FIFO.
module fp_addsub_issue
    import fp_issue_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int TAG_W = TAG_W_DEFAULT
) (
    input  logic             clock,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic             cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic             s_axis_a_tvalid,
    input  logic             s_axis_a_tready,
    output logic [31:0]      s_axis_a_tdata,
    output logic             s_axis_b_tvalid,
    input  logic             s_axis_b_tready,
    output logic [31:0]      s_axis_b_tdata,
    output logic             s_axis_operation_tvalid,
    input  logic             s_axis_operation_tready,
    output logic [7:0]       s_axis_operation_tdata,
    input  logic             m_axis_result_tvalid,
    output logic             m_axis_result_tready,
    input  logic [31:0]      m_axis_result_tdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             err_orphan
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    issue_state_t     state;
    logic [31:0]      a_reg;
    logic [31:0]      b_reg;
    logic             op_reg;
    logic             cmd_hs;
    logic             res_hs;
    logic             a_pend;
    logic             b_pend;
    logic             op_pend;
    logic [TAG_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign cmd_ready = (state == IDLE) && (fifo_count < CNT_W'(DEPTH)) && !fifo_full;
    assign cmd_hs    = cmd_valid && cmd_ready;

    // A channel stays pending while its tvalid is up and the core has not taken it.
    assign a_pend  = s_axis_a_tvalid && !s_axis_a_tready;
    assign b_pend  = s_axis_b_tvalid && !s_axis_b_tready;
    assign op_pend = s_axis_operation_tvalid && !s_axis_operation_tready;

    assign s_axis_a_tdata         = a_reg;
    assign s_axis_b_tdata         = b_reg;
    assign s_axis_operation_tdata = op_reg ? OP_SUB : OP_ADD;

    assign m_axis_result_tready = !rsp_valid || rsp_ready;
    assign res_hs               = m_axis_result_tvalid && m_axis_result_tready;

    fp_tag_fifo #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W),
        .CNT_W (CNT_W)
    ) u_tag_fifo (
        .clock    (clock),
        .rstn     (rstn),
        .push     (cmd_hs),
        .push_tag (cmd_tag),
        .pop      (res_hs),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    // Issue FSM: latch a command, then retire each operand channel independently.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state                   <= IDLE;
            a_reg                   <= '0;
            b_reg                   <= '0;
            op_reg                  <= 1'b0;
            s_axis_a_tvalid         <= 1'b0;
            s_axis_b_tvalid         <= 1'b0;
            s_axis_operation_tvalid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_hs) begin
                        a_reg                   <= cmd_a;
                        b_reg                   <= cmd_b;
                        op_reg                  <= cmd_op;
                        s_axis_a_tvalid         <= 1'b1;
                        s_axis_b_tvalid         <= 1'b1;
                        s_axis_operation_tvalid <= 1'b1;
                        state                   <= SEND;
                    end
                end
                SEND: begin
                    s_axis_a_tvalid         <= a_pend;
                    s_axis_b_tvalid         <= b_pend;
                    s_axis_operation_tvalid <= op_pend;
                    if (!a_pend && !b_pend && !op_pend)
                        state <= IDLE;
                end
            endcase
        end
    end

    // Response register: load on a tagged result, hold until the consumer takes it.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_tag   <= '0;
        end else if (res_hs && !fifo_empty) begin
            rsp_valid <= 1'b1;
            rsp_data  <= m_axis_result_tdata;
            rsp_tag   <= fifo_head;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Sticky flag for a result that arrives with no operation outstanding.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn)
            err_orphan <= 1'b0;
        else if (res_hs && fifo_empty)
            err_orphan <= 1'b1;
    end

endmodule
